result_drain_fsm: RTL and testbench

//  Transmit-side counterpart of the array loader. On start_i, reads the array's results
//  one column at a time. Per column: assert a one-hot column read strobe, capture Dim

---
 rtl/drain_pkg.sv | 15 +
 rtl/result_drain_fsm_word_shift_reg.sv | 36 +++
 rtl/result_drain_fsm.sv | 158 +++++++++++++++
 tb/tb_result_drain_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drain_pkg.sv
// Shared types and constants for the result drain path.
package drain_pkg;

    // Word width shared with the array loader.
    localparam int WORD_W = 77;

    // Drain controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } drain_state_e;

endpackage

// File: rtl/result_drain_fsm_word_shift_reg.sv
// word_shift_reg: Dim-deep parallel-load register that shifts toward its head.
// The head is element Dim-1, so a freshly loaded column leaves in the order
// data_i[Dim-1], data_i[Dim-2], ..., data_i[0]. Vacated slots fill with zero.
module word_shift_reg #(
    parameter int Dim = 4,
    parameter int W   = 77
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [Dim-1:0][W-1:0] data_i,
    output logic [W-1:0]          head_o
);

    logic [Dim-1:0][W-1:0] r_buf;

    // Parallel load has priority; otherwise move every word one slot toward the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf <= '0;
        end else if (load_i) begin
            r_buf <= data_i;
        end else if (shift_i) begin
            for (int k = Dim - 1; k > 0; k--) begin
                r_buf[k] <= r_buf[k-1];
            end
            r_buf[0] <= '0;
        end else begin
            r_buf <= r_buf;
        end
    end

    assign head_o = r_buf[Dim-1];

endmodule

// File: rtl/result_drain_fsm.sv
// result_drain_fsm: reads the compute array one column at a time and streams
// each column out word by word over a valid/ready link.
// Optional feature macro: RESULT_DRAIN_LAST_EN adds last_o (last word of a column).
module result_drain_fsm
    import drain_pkg::*;
#(
    parameter int Dim = 4,
    parameter int W   = WORD_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [Dim-1:0][W-1:0] data_col_i,
    output logic [Dim-1:0]        col_rd_o,
    output logic [W-1:0]          word_o,
    output logic                  word_v_o,
    input  logic                  word_r_i,
    output logic                  busy_o,
`ifdef RESULT_DRAIN_LAST_EN
    output logic                  last_o,
`endif
    output logic                  done_o
);

    localparam int                CNT_W    = $clog2(Dim + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(Dim - 1);

    drain_state_e     r_state;
    logic [CNT_W-1:0] r_col_cnt;
    logic [CNT_W-1:0] r_row_cnt;
    logic [Dim-1:0]   r_col_rd;
    logic             r_word_v;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_xfer;
    logic             w_last_row;
    logic             w_last_col;
    logic [W-1:0]     w_head;

    // One-hot decode of a column index.
    function automatic logic [Dim-1:0] col_onehot(input logic [CNT_W-1:0] idx);
        logic [Dim-1:0] v;
        for (int k = 0; k < Dim; k++) begin
            v[k] = (idx == CNT_W'(k));
        end
        return v;
    endfunction

    assign w_load     = (r_state == CAPTURE);
    assign w_xfer     = (r_state == SEND) && r_word_v && word_r_i;
    assign w_last_row = (r_row_cnt == LAST_IDX);
    assign w_last_col = (r_col_cnt == LAST_IDX);

    word_shift_reg #(
        .Dim (Dim),
        .W   (W)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_load),
        .shift_i (w_xfer),
        .data_i  (data_col_i),
        .head_o  (w_head)
    );

    // Drain controller: state, counters and all registered handshake/status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_col_rd  <= '0;
            r_word_v  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state   <= CAPTURE;
                        r_col_cnt <= '0;
                        r_col_rd  <= col_onehot('0);
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                CAPTURE: begin
                    // The strobe lasts this single cycle; the buffer loads at its end.
                    r_state   <= SEND;
                    r_col_rd  <= '0;
                    r_row_cnt <= '0;
                    r_word_v  <= 1'b1;
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_last_row) begin
                            r_word_v <= 1'b0;
                            if (w_last_col) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= CAPTURE;
                                r_col_cnt <= r_col_cnt + CNT_W'(1);
                                r_col_rd  <= col_onehot(r_col_cnt + CNT_W'(1));
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= SEND;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_col_cnt <= '0;
                    r_row_cnt <= '0;
                    r_col_rd  <= '0;
                    r_word_v  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESULT_DRAIN_LAST_EN
    logic r_last;

    // Flags the word currently offered when it is the final row of its column.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_last <= (LAST_IDX == '0);
        end else if (w_xfer) begin
            r_last <= !w_last_row && ((r_row_cnt + CNT_W'(1)) == LAST_IDX);
        end else if (r_state == SEND) begin
            r_last <= r_last;
        end else begin
            r_last <= 1'b0;
        end
    end

    assign last_o = r_last;
`endif

    assign col_rd_o = r_col_rd;
    assign word_o   = w_head;
    assign word_v_o = r_word_v;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_result_drain_fsm.sv
// Self-checking bench for result_drain_fsm: a table of per-cycle control
// expectations, randomized drains against a queue-based reference, and
// hand-written reset / backpressure sequences.
module tb_result_drain_fsm;

    localparam int Dim = 4;
    localparam int W   = 77;
    localparam logic [W-1:0] FILLER = W'(64'hA5A5_C3C3_5A5A_3C3C);

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  start_i = 1'b0;
    logic [Dim-1:0][W-1:0] data_col_i;
    logic [Dim-1:0]        col_rd_o;
    logic [W-1:0]          word_o;
    logic                  word_v_o;
    logic                  word_r_i = 1'b0;
    logic                  busy_o;
    logic                  done_o;
`ifdef RESULT_DRAIN_LAST_EN
    logic                  last_o;
`endif

    result_drain_fsm #(.Dim(Dim), .W(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .data_col_i (data_col_i),
        .col_rd_o   (col_rd_o),
        .word_o     (word_o),
        .word_v_o   (word_v_o),
        .word_r_i   (word_r_i),
        .busy_o     (busy_o),
`ifdef RESULT_DRAIN_LAST_EN
        .last_o     (last_o),
`endif
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference array contents and expected egress order.
    logic [Dim-1:0][W-1:0] mat [Dim];
    logic [W-1:0]          exp_q [$];
    int                    xfer_cnt = 0;
    int                    pulses   = 0;
    bit                    mon_en   = 1'b0;
    bit                    prev_stall = 1'b0;
    logic [W-1:0]          prev_word = '0;
    logic [Dim-1:0]        prev_col_rd = '0;

    // Array model: the addressed column is presented only while its strobe is high.
    always_comb begin
        for (int k = 0; k < Dim; k++) data_col_i[k] = FILLER;
        for (int c = 0; c < Dim; c++) begin
            if (col_rd_o[c]) data_col_i = mat[c];
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // New random matrix; expected stream is column 0..Dim-1, each from row Dim-1 down to 0.
    task automatic load_matrix();
        logic [W-1:0] w;
        exp_q.delete();
        for (int c = 0; c < Dim; c++) begin
            for (int r = 0; r < Dim; r++) begin
                w = W'({$urandom, $urandom, $urandom});
                w[15:8] = 8'(c);
                w[7:0]  = 8'(r);
                mat[c][r] = w;
            end
        end
        for (int c = 0; c < Dim; c++) begin
            for (int r = Dim - 1; r >= 0; r--) exp_q.push_back(mat[c][r]);
        end
        xfer_cnt    = 0;
        pulses      = 0;
        prev_stall  = 1'b0;
        prev_col_rd = '0;
        mon_en      = 1'b1;
    endtask

    // Link monitor, sampled mid-cycle while inputs are stable.
    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (col_rd_o != '0) begin
                    pulses++;
                    check("col_rd_column", W'(col_rd_o), W'(1 << (xfer_cnt / Dim)));
                    check("col_rd_single_cycle", W'(prev_col_rd), '0);
                end
                if (prev_stall) begin
                    check("stall_valid_held", W'(word_v_o), W'(1'b1));
                    check("stall_word_held", word_o, prev_word);
                end
`ifdef RESULT_DRAIN_LAST_EN
                check("last_o", W'(last_o), W'(word_v_o && (xfer_cnt % Dim == Dim - 1)));
`endif
                if (word_v_o && word_r_i) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", word_o, FILLER);
                    end else begin
                        check("word_order", word_o, exp_q.pop_front());
                    end
                    xfer_cnt++;
                end
                prev_stall  = word_v_o && !word_r_i;
                prev_word   = word_o;
                prev_col_rd = col_rd_o;
            end
        end
    end

    // Advance until done_o, drawing ready per cycle; n counts edges after the start edge.
    task automatic wait_done(input int pct, input int stall_from, input int stall_len,
                             input int n0, output int n);
        bit seen;
        n = n0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            if (n + 1 >= stall_from && n + 1 < stall_from + stall_len) word_r_i = 1'b0;
            else word_r_i = ($urandom_range(99) < pct);
            @(posedge clk_i); #1;
            n++;
            seen = done_o;
        end
        if (!seen) check("done_timeout", W'(0), W'(1));
    endtask

    task automatic run_drain(input string name, input int pct, input int stall_from,
                             input int stall_len, input int exp_n);
        int n;
        load_matrix();
        start_i  = 1'b1;
        word_r_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done(pct, stall_from, stall_len, 0, n);
        if (exp_n > 0) check({name, "_latency"}, W'(n), W'(exp_n));
        check({name, "_all_words"}, W'(exp_q.size()), '0);
        check({name, "_strobes"}, W'(pulses), W'(Dim));
        check({name, "_done_busy"}, W'({done_o, busy_o, word_v_o}), W'(3'b100));
    endtask

    typedef struct {
        logic           start;
        logic           rdy;
        logic [Dim-1:0] col_rd;
        logic           v;
        logic           busy;
        logic           done;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        // start edge is row 1; rows 2-3 have ready low / ignored; row 4 pulses start during SEND
        tbl[0] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", W'({col_rd_o, word_v_o, busy_o, done_o}), '0);
        check("reset_word", word_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table-driven opening of a drain, then run to completion with ready high.
        load_matrix();
        for (int i = 0; i < 10; i++) begin
            start_i  = tbl[i].start;
            word_r_i = tbl[i].rdy;
            @(posedge clk_i); #1;
            check($sformatf("tbl%0d_col_rd", i), W'(col_rd_o), W'(tbl[i].col_rd));
            check($sformatf("tbl%0d_ctrl", i), W'({word_v_o, busy_o, done_o}),
                  W'({tbl[i].v, tbl[i].busy, tbl[i].done}));
        end
        start_i = 1'b0;
        wait_done(100, 0, 0, 8, n);
        check("tbl_done_latency", W'(n), W'(Dim * (Dim + 1) + 2));
        check("tbl_all_words", W'(exp_q.size()), '0);

        // Full drain from DONE, ready always high.
        run_drain("full", 100, 0, 0, Dim * (Dim + 1));
        // Five stalled cycles in the middle of column 1.
        run_drain("stall5", 100, 8, 5, Dim * (Dim + 1) + 5);
        // Random backpressure.
        for (int i = 0; i < 3; i++) run_drain("rand50", 50, 0, 0, 0);

        // Async reset mid-SEND at column 2, row 1.
        load_matrix();
        start_i  = 1'b1;
        word_r_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 0; k < 2 * (Dim + 1) + 2; k++) begin
            @(posedge clk_i); #1;
        end
        check("pre_reset_sent", W'(xfer_cnt), W'(2 * Dim + 1));
        #2;
        mon_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("async_reset_ctrl", W'({col_rd_o, word_v_o, busy_o, done_o}), '0);
        check("async_reset_word", word_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("post_reset_idle", W'({col_rd_o, word_v_o, busy_o, done_o}), '0);
        run_drain("after_reset", 100, 0, 0, Dim * (Dim + 1));

        // done_o holds without a new start.
        word_r_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("done_hold", W'({done_o, busy_o, word_v_o, col_rd_o}), W'({3'b100, 4'b0000}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
